// File: rtl/sorter_pkg.sv
// Shared definitions for the sorter register controller.
// Holds the element count, the signed element and array types, the register
// offsets inside the bus window, the CTRL/STATUS bit positions and the FSM
// state encoding.
package sorter_pkg;

  localparam int NUM_ELEM = 8;

  typedef logic signed [31:0] elem_t;
  typedef elem_t [NUM_ELEM-1:0] elem_arr_t;

  // Byte offsets from the window base.
  localparam logic [7:0] OFF_CTRL      = 8'h00;
  localparam logic [7:0] OFF_STATUS    = 8'h04;
  localparam logic [7:0] OFF_IN_FIRST  = 8'h08;
  localparam logic [7:0] OFF_IN_LAST   = 8'h24;
  localparam logic [7:0] OFF_OUT_FIRST = 8'h28;
  localparam logic [7:0] OFF_OUT_LAST  = 8'h44;
  localparam logic [7:0] OFF_COUNT     = 8'h48;
  localparam logic [7:0] OFF_SETTLE    = 8'h4C;

  // Size of the window in bytes (last register at 0x4C).
  localparam logic [31:0] WINDOW_BYTES = 32'h0000_0050;

  // CTRL bits.
  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_CLR_ERR  = 2;

  // STATUS bits.
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/sorter_ctrl.sv
// Bus-mapped controller for an external combinational 8-element sorter.
// Software loads IN[0..7], writes START, and the block latches the operands
// onto sort_in_bo, waits SETTLE_CYCLES for the sorter, then captures
// sort_out_bi into OUT[0..7], sets DONE and bumps SORT_COUNT.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   bus_req_i/bus_we_i      request strobe and write select
//   bus_addr_bi/bus_be_bi   byte address and byte enables
//   bus_wdata_bi            write data
//   bus_ack_o               request accepted (same cycle as bus_req_i)
//   bus_resp_o/bus_rdata_bo one-cycle read response, data zero otherwise
//   sort_in_bo              operands driven to the external sorter
//   sort_out_bi             results returned by the external sorter
module sorter_ctrl
  import sorter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_1000,
  parameter int          SETTLE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output elem_arr_t   sort_in_bo,
  input  elem_arr_t   sort_out_bi
);

  logic [31:0] offset_s;
  logic [7:0]  off8_s;
  logic        in_window_s;
  logic        is_in_s;
  logic        is_out_s;
  logic [2:0]  in_idx_s;
  logic [2:0]  out_idx_s;
  logic        ctrl_wr_s;
  logic        start_wr_s;
  logic        clr_done_wr_s;
  logic        clr_err_wr_s;
  logic        busy_s;
  logic [31:0] rd_val_s;

  elem_arr_t   in_r;
  elem_arr_t   out_r;
  logic [31:0] count_r;
  logic        done_r;
  logic        err_r;
  logic [3:0]  cnt_r;
  state_t      state_r;

  assign bus_ack_o = bus_req_i;

  // Decode relative to the window base; misaligned addresses fall outside.
  assign offset_s    = bus_addr_bi - BASE_ADDR;
  assign off8_s      = offset_s[7:0];
  assign in_window_s = (offset_s < WINDOW_BYTES) && (offset_s[1:0] == 2'b00);
  assign is_in_s     = in_window_s && (off8_s >= OFF_IN_FIRST) && (off8_s <= OFF_IN_LAST);
  assign is_out_s    = in_window_s && (off8_s >= OFF_OUT_FIRST) && (off8_s <= OFF_OUT_LAST);
  assign in_idx_s    = 3'((off8_s - OFF_IN_FIRST) >> 2);
  assign out_idx_s   = 3'((off8_s - OFF_OUT_FIRST) >> 2);

  // CTRL only acts when its low byte is enabled.
  assign ctrl_wr_s     = bus_req_i && bus_we_i && in_window_s && (off8_s == OFF_CTRL) && bus_be_bi[0];
  assign start_wr_s    = ctrl_wr_s && bus_wdata_bi[CTRL_START];
  assign clr_done_wr_s = ctrl_wr_s && bus_wdata_bi[CTRL_CLR_DONE];
  assign clr_err_wr_s  = ctrl_wr_s && bus_wdata_bi[CTRL_CLR_ERR];

  assign busy_s = (state_r != ST_IDLE);

  // Read data mux; CTRL reads as zero.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    if (off8_s == OFF_STATUS) begin
      rd_val_s[STAT_BUSY] = busy_s;
      rd_val_s[STAT_DONE] = done_r;
      rd_val_s[STAT_ERR]  = err_r;
    end else if (is_in_s) begin
      rd_val_s = in_r[in_idx_s];
    end else if (is_out_s) begin
      rd_val_s = out_r[out_idx_s];
    end else if (off8_s == OFF_COUNT) begin
      rd_val_s = count_r;
    end else if (off8_s == OFF_SETTLE) begin
      rd_val_s = 32'(SETTLE_CYCLES);
    end else begin
      rd_val_s = 32'h0000_0000;
    end
  end

  // Read response: one cycle after acceptance, zero data when not responding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_resp_o   <= 1'b0;
      bus_rdata_bo <= 32'h0000_0000;
    end else if (bus_req_i && !bus_we_i && in_window_s) begin
      bus_resp_o   <= 1'b1;
      bus_rdata_bo <= rd_val_s;
    end else begin
      bus_resp_o   <= 1'b0;
      bus_rdata_bo <= 32'h0000_0000;
    end
  end

  // IN registers with per-byte write enables; free to change during a sort
  // because the sorter sees the latched operand copy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_r <= '0;
    end else if (bus_req_i && bus_we_i && is_in_s) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_be_bi[b]) begin
          in_r[in_idx_s][8*b +: 8] <= bus_wdata_bi[8*b +: 8];
        end
      end
    end
  end

  // Sort sequencing FSM plus the DONE/ERR flags and result capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      sort_in_bo <= '0;
      out_r      <= '0;
      count_r    <= 32'h0000_0000;
      cnt_r      <= 4'd0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_wr_s) begin
            sort_in_bo <= in_r;
            cnt_r      <= 4'(SETTLE_CYCLES - 1);
            state_r    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == 4'd0) begin
            state_r <= ST_CAPTURE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_CAPTURE: begin
          out_r   <= sort_out_bi;
          count_r <= count_r + 32'd1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      // Capture wins over a coincident CLR_DONE.
      if (state_r == ST_CAPTURE) begin
        done_r <= 1'b1;
      end else if ((start_wr_s && !busy_s) || clr_done_wr_s) begin
        done_r <= 1'b0;
      end

      // A rejected START is sticky until explicitly cleared.
      if (start_wr_s && busy_s) begin
        err_r <= 1'b1;
      end else if (clr_err_wr_s) begin
        err_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sorter_ctrl.sv
// Directed bench for sorter_ctrl with a behavioural model of the external
// sorter and a queue of expected read data.
module tb_sorter_ctrl;
  import sorter_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        bus_req_i;
  logic        bus_we_i;
  logic [31:0] bus_addr_bi;
  logic [3:0]  bus_be_bi;
  logic [31:0] bus_wdata_bi;
  logic        bus_ack_o;
  logic        bus_resp_o;
  logic [31:0] bus_rdata_bo;
  elem_arr_t   sort_in_bo;
  elem_arr_t   sort_out_bi;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  logic [31:0] in_vals   [8] = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'hFFFF_FFF8, 32'd2, 32'd9, 32'd1};
  logic [31:0] sorted_a  [8] = '{32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd0, 32'd1, 32'd2, 32'd5, 32'd7, 32'd9};

  sorter_ctrl #(.BASE_ADDR(BASE), .SETTLE_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_bi(bus_addr_bi),
    .bus_be_bi(bus_be_bi), .bus_wdata_bi(bus_wdata_bi),
    .bus_ack_o(bus_ack_o), .bus_resp_o(bus_resp_o), .bus_rdata_bo(bus_rdata_bo),
    .sort_in_bo(sort_in_bo), .sort_out_bi(sort_out_bi)
  );

  always #5 clk_i = ~clk_i;

  // Reference model of the external combinational sorter (ascending, signed).
  function automatic elem_arr_t sort8(input elem_arr_t a);
    elem_t t;
    for (int i = 0; i < NUM_ELEM; i++) begin
      for (int j = 0; j < NUM_ELEM - 1 - i; j++) begin
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
      end
    end
    return a;
  endfunction

  assign sort_out_bi = sort8(sort_in_bo);

  // All tasks start and end on a falling edge, so calls chain back-to-back.
  task automatic wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] be);
    bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_bi = BASE + 32'(off);
    bus_be_bi = be; bus_wdata_bi = data;
    @(negedge clk_i);
    bus_req_i = 1'b0; bus_we_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string t;
    bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = BASE + 32'(off); bus_be_bi = 4'hF;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk_i);
    bus_req_i = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (bus_resp_o === 1'b1 && bus_rdata_bo === e) else begin
      miscompares++;
      $error("FAIL %s: resp=%b rdata=%h, wanted resp=1 rdata=%h", t, bus_resp_o, bus_rdata_bo, e);
    end
  endtask

  task automatic idle(input string tag);
    @(negedge clk_i);
    vectors++;
    assert (bus_resp_o === 1'b0 && bus_rdata_bo === 32'h0000_0000) else begin
      miscompares++;
      $error("FAIL %s: resp=%b rdata=%h, wanted resp=0 rdata=0", tag, bus_resp_o, bus_rdata_bo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; bus_req_i = 1'b0; bus_we_i = 1'b0;
    bus_addr_bi = 32'h0; bus_be_bi = 4'h0; bus_wdata_bi = 32'h0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state and constant registers.
    rd(OFF_STATUS, 32'h0, "rst_status");
    rd(OFF_COUNT, 32'h0, "rst_count");
    rd(OFF_OUT_FIRST, 32'h0, "rst_out0");
    rd(OFF_SETTLE, 32'd2, "settle");
    idle("resp_one_cycle");
    rd(OFF_CTRL, 32'h0, "ctrl_reads_0");

    // Basic sort with cycle-exact DONE timing.
    for (int i = 0; i < 8; i++) wr(8'(OFF_IN_FIRST + 8'(4*i)), in_vals[i], 4'hF);
    rd(8'h0C, 32'hFFFF_FFFD, "in1_rb");
    wr(OFF_CTRL, 32'h1, 4'h1);
    rd(OFF_STATUS, 32'h1, "busy_e1");
    rd(OFF_STATUS, 32'h1, "busy_e2");
    rd(OFF_STATUS, 32'h1, "busy_e3");
    rd(OFF_STATUS, 32'h2, "done_e4");
    for (int i = 0; i < 8; i++) rd(8'(OFF_OUT_FIRST + 8'(4*i)), sorted_a[i], $sformatf("sortA_out%0d", i));
    rd(OFF_COUNT, 32'd1, "count1");

    // START and IN write during BUSY: original data sorted, ERR raised.
    wr(OFF_CTRL, 32'h1, 4'h1);
    wr(OFF_IN_FIRST, 32'h7FFF_FFFF, 4'hF);
    wr(OFF_CTRL, 32'h1, 4'h1);
    rd(OFF_STATUS, 32'h5, "busy_err");
    rd(OFF_STATUS, 32'h6, "done_err");
    for (int i = 0; i < 8; i++) rd(8'(OFF_OUT_FIRST + 8'(4*i)), sorted_a[i], $sformatf("keep_out%0d", i));
    rd(OFF_COUNT, 32'd2, "count2");
    wr(OFF_CTRL, 32'h4, 4'h1);
    rd(OFF_STATUS, 32'h2, "clr_err");
    wr(OFF_CTRL, 32'h2, 4'hE);
    rd(OFF_STATUS, 32'h2, "ctrl_be0_off");
    wr(OFF_CTRL, 32'h2, 4'h1);
    rd(OFF_STATUS, 32'h0, "clr_done");

    // Second sort picks up the new IN[0]; OUT holds old results while busy.
    wr(OFF_CTRL, 32'h1, 4'h1);
    rd(8'h3C, 32'd5, "busy_old_out5");
    rd(8'h44, 32'd9, "busy_old_out7");
    idle("capture_edge");
    rd(8'h44, 32'h7FFF_FFFF, "new_out7");
    rd(8'h3C, 32'd7, "new_out5");
    rd(OFF_COUNT, 32'd3, "count3");

    // START with CLR_DONE: DONE stays 0 until capture.
    wr(OFF_CTRL, 32'h3, 4'h1);
    rd(OFF_STATUS, 32'h1, "start_clr_busy");
    idle("w1");
    idle("w2");
    rd(OFF_STATUS, 32'h2, "start_clr_done");

    // CLR_DONE landing on the capture edge: DONE ends at 1.
    wr(OFF_CTRL, 32'h1, 4'h1);
    idle("w3");
    idle("w4");
    wr(OFF_CTRL, 32'h2, 4'h1);
    rd(OFF_STATUS, 32'h2, "clr_vs_capture");
    rd(OFF_COUNT, 32'd5, "count5");

    // Byte enables and read-only writes.
    wr(8'h0C, 32'h0, 4'hF);
    wr(8'h0C, 32'hAABB_CCDD, 4'b0010);
    rd(8'h0C, 32'h0000_CC00, "in1_be");
    wr(OFF_OUT_FIRST, 32'h1234, 4'hF);
    rd(OFF_OUT_FIRST, 32'hFFFF_FFF8, "out_ro");
    wr(OFF_COUNT, 32'hDEAD, 4'hF);
    rd(OFF_COUNT, 32'd5, "count_ro");

    // Reset one cycle after START abandons the sort.
    wr(OFF_CTRL, 32'h1, 4'h1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    vectors++;
    assert (sort_in_bo === '0) else begin
      miscompares++;
      $error("FAIL rst_sort_in: got %h, wanted 0", sort_in_bo);
    end
    idle("w5");
    idle("w6");
    idle("w7");
    rd(OFF_STATUS, 32'h0, "mid_rst_status");
    for (int i = 0; i < 8; i++) rd(8'(OFF_OUT_FIRST + 8'(4*i)), 32'h0, $sformatf("mid_rst_out%0d", i));
    rd(OFF_COUNT, 32'h0, "mid_rst_count");
    rd(OFF_IN_FIRST, 32'h0, "mid_rst_in0");

    // Read outside the window gets no response.
    bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = BASE + 32'h100;
    @(negedge clk_i);
    bus_req_i = 1'b0;
    vectors++;
    assert (bus_resp_o === 1'b0 && bus_rdata_bo === 32'h0) else begin
      miscompares++;
      $error("FAIL out_of_window: resp=%b rdata=%h, wanted resp=0 rdata=0", bus_resp_o, bus_rdata_bo);
    end
    idle("after_oow");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
